// File: rtl/psg_bus_pkg.sv
// Shared types and helpers for the PSG bus sequencer: FSM states, the queued
// write request and the TurboSound chip-select prefix.
package psg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    STROBE  = 2'd2,
    RECOVER = 2'd3
  } psg_state_t;

  typedef struct packed {
    logic       is_addr;
    logic [7:0] data;
  } psg_req_t;

  localparam logic [6:0] SEL_PREFIX = 7'h7F;

  // One-hot BDIR/BC lane for a chip index.
  function automatic logic [1:0] chip_mask(input logic chip);
    return chip ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/psg_bus_ctrl.sv
// Turns CPU I/O writes to FFFD/BFFD into psg_ce-aligned BDIR/BC bus cycles for
// one or two ym2149 chips, with a single-entry holding register.
module psg_bus_ctrl
  import psg_bus_pkg::*;
#(
  parameter int TURBOSOUND = 1,
  parameter int HOLD_TICKS = 2
) (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic        psg_ce,
  input  logic [15:0] A,
  input  logic [7:0]  din,
  input  logic        io_we,
  input  logic        io_rd,
  output logic [7:0]  psg_di,
  output logic [1:0]  psg_bdir,
  output logic [1:0]  psg_bc,
  input  logic [7:0]  psg_do0,
  input  logic [7:0]  psg_do1,
  output logic [7:0]  psg_dout,
  output logic        busy,
  output logic        wait_req,
  output logic        overrun,
  output logic        active_chip
);

  localparam logic [2:0] HOLD_T = 3'(HOLD_TICKS);

  psg_state_t state;
  psg_req_t   hold_req;
  psg_req_t   new_req;
  logic       hold_full;
  logic       io_we_q;
  logic       work_chip;
  logic [2:0] tick;
  logic       psg_sel;
  logic       capture;
  logic       sel_write;
  logic       req_valid;
  logic       unload;
  logic       unused_bits;

  assign psg_sel   = A[0] & A[15] & ~A[1];
  assign capture   = io_we & ~io_we_q & psg_sel;
  assign sel_write = capture & (TURBOSOUND != 0) & A[14] & (din[7:1] == SEL_PREFIX);
  assign req_valid = capture & ~sel_write;
  assign new_req   = '{is_addr: A[14], data: din};
  assign unload    = (state == IDLE) & hold_full;

  assign busy     = (state != IDLE) | hold_full;
  assign wait_req = hold_full;
  assign psg_dout = (psg_sel & A[14]) ? (active_chip ? psg_do1 : psg_do0) : 8'hFF;

  assign unused_bits = &{1'b0, io_rd, A[13:2]};

  // Request payload is qualified by hold_full, so it carries no reset.
  always_ff @(posedge clk_sys) begin
    if (req_valid && (!hold_full || unload))
      hold_req <= new_req;
  end

  // Capture, holding-register occupancy and bus FSM.
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      io_we_q     <= 1'b0;
      active_chip <= 1'b0;
      hold_full   <= 1'b0;
      overrun     <= 1'b0;
      state       <= IDLE;
      work_chip   <= 1'b0;
      tick        <= 3'd0;
      psg_di      <= 8'h00;
      psg_bdir    <= 2'b00;
      psg_bc      <= 2'b00;
    end else begin
      io_we_q <= io_we;
      if (sel_write)
        active_chip <= ~din[0];

      // A slot freed by IDLE on this edge is immediately reusable.
      if (req_valid && (!hold_full || unload)) begin
        hold_full <= 1'b1;
      end else begin
        if (req_valid)
          overrun <= 1'b1;
        if (unload)
          hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (hold_full) begin
            work_chip <= active_chip;
            psg_di    <= hold_req.data;
            psg_bc    <= hold_req.is_addr ? chip_mask(active_chip) : 2'b00;
            psg_bdir  <= 2'b00;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (psg_ce) begin
            state    <= STROBE;
            tick     <= 3'd0;
            psg_bdir <= chip_mask(work_chip);
          end
        end
        STROBE: begin
          if (psg_ce) begin
            tick <= tick + 3'd1;
            if (tick + 3'd1 == HOLD_T) begin
              state    <= RECOVER;
              psg_bdir <= 2'b00;
              psg_bc   <= 2'b00;
            end
          end
        end
        RECOVER: begin
          if (psg_ce)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
